// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared RV32I pipeline constants and fetch FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int                XLEN              = 32;
    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0]   NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0]   WORD_MASK         = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0]   INSTR_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        KILL = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_slot.sv
// ============================================================================
// Module   : fetch_slot
// Brief    : Pipeline slot register (valid/data/addr) with load, hold, flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_slot #(
    parameter int                  DATA_W     = 32,
    parameter int                  ADDR_W     = 32,
    parameter logic [DATA_W-1:0]   FLUSH_DATA = '0,
    parameter logic [ADDR_W-1:0]   RESET_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                flush,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [ADDR_W-1:0]   addr_in,
    output logic                valid,
    output logic [DATA_W-1:0]   data,
    output logic [ADDR_W-1:0]   addr
);

    // Flush wins over load; the address is left alone on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= FLUSH_DATA;
            addr  <= RESET_ADDR;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= FLUSH_DATA;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            addr  <= addr_in;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I fetch stage, one outstanding imem request, redirect/stall.
//            Optional macro FETCH_MISALIGN_EN adds sticky fetch_misaligned.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    output logic                imem_rready,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic [XLEN-1:0]     instruction,
    output logic [XLEN-1:0]     pc_address,
    output logic                valid
`ifdef FETCH_MISALIGN_EN
    ,
    output logic                fetch_misaligned
`endif
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_pc_out;
    logic [XLEN-1:0]    r_held_addr;
    logic               r_pend_kill;
    logic               r_misaligned;
    logic               w_accept;
    logic               w_grant;
    logic               w_kill_grant;
    logic               w_mis_now;
    logic               w_load;
    logic               w_flush;

`ifdef FETCH_MISALIGN_EN
    assign w_mis_now        = redirect & (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = r_misaligned;
`else
    assign w_mis_now        = 1'b0;
`endif

    assign imem_rready = (r_state == KILL) | ~valid | ~stall;
    assign w_accept    = imem_rvalid & imem_rready;

    // A request killed by a redirect before its grant keeps its original
    // address on the bus until granted, while pc already holds the target.
    assign imem_addr   = r_pend_kill ? r_held_addr : r_pc;

    always_comb begin
        imem_req     = 1'b0;
        w_state_next = r_state;
        case (r_state)
            IDLE:       imem_req = rst & (r_pend_kill | ~r_misaligned);
            BUSY, KILL: imem_req = w_accept & ~r_misaligned;
            default:    imem_req = 1'b0;
        endcase

        w_grant      = imem_req & imem_gnt;
        w_kill_grant = w_grant & (r_pend_kill | redirect);

        case (r_state)
            IDLE: begin
                if (!imem_req) begin
                    w_state_next = HALT;
                end else if (w_grant) begin
                    w_state_next = w_kill_grant ? KILL : BUSY;
                end
            end
            BUSY, KILL: begin
                if (w_accept) begin
                    if (w_grant) begin
                        w_state_next = w_kill_grant ? KILL : BUSY;
                    end else begin
                        w_state_next = r_misaligned ? HALT : IDLE;
                    end
                end else if (redirect) begin
                    w_state_next = KILL;
                end
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= RESET_PC;
            r_pc_out     <= RESET_PC;
            r_held_addr  <= RESET_PC;
            r_pend_kill  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            if (redirect) begin
                r_pc <= word_align(redirect_pc);
            end else if (w_grant && !r_pend_kill) begin
                r_pc <= r_pc + INSTR_BYTES;
            end

            if (w_grant) begin
                r_pc_out <= imem_addr;
            end

            if (redirect && imem_req && !imem_gnt && !r_pend_kill) begin
                r_held_addr <= r_pc;
            end

            r_pend_kill <= imem_req & ~imem_gnt & (r_pend_kill | redirect);

            if (w_mis_now) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    // A consumed slot empties unless a fresh response refills it the same edge.
    assign w_load  = (r_state == BUSY) & w_accept & ~redirect;
    assign w_flush = redirect | (valid & ~stall & ~w_load);

    fetch_slot #(
        .DATA_W     (XLEN),
        .ADDR_W     (XLEN),
        .FLUSH_DATA (NOP_INSTR),
        .RESET_ADDR (RESET_PC)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .flush   (w_flush),
        .data_in (imem_rdata),
        .addr_in (r_pc_out),
        .valid   (valid),
        .data    (instruction),
        .addr    (pc_address)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: instruction memory model plus an in-order expected
// PC stream, directed scenarios followed by randomized stall/grant/redirect.
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic        imem_rready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_address;
    logic        valid;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_misaligned;
`endif

    logic        gnt_ok = 1'b1;
    int          lat_next = 0;
    logic        m_has;
    logic [31:0] m_addr;
    int          m_cnt;

    int          checks = 0;
    int          passes = 0;
    int          deliveries = 0;

    logic [31:0] exp_pc = 32'h0;
    bit          exp_halt = 1'b0;
    bit          redir_prev = 1'b0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rready (imem_rready),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_address  (pc_address),
        .valid       (valid)
`ifdef FETCH_MISALIGN_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_0113;
            default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: one response per grant, after lat_next idle cycles.
    assign imem_gnt    = imem_req & gnt_ok;
    assign imem_rvalid = m_has && (m_cnt == 0);
    assign imem_rdata  = instr_of(m_addr);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_has  <= 1'b0;
            m_addr <= 32'h0;
            m_cnt  <= 0;
        end else if (imem_req && imem_gnt) begin
            m_has  <= 1'b1;
            m_addr <= imem_addr;
            m_cnt  <= lat_next;
        end else if (imem_rvalid && imem_rready) begin
            m_has  <= 1'b0;
        end else if (m_has && m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
        end
    end

    // Reference: decode sees exactly the sequential PC stream, restarted at
    // every redirect target; each consumed slot advances it by one word.
    always @(negedge clk) begin
        if (!rst) begin
            exp_pc     = 32'h0;
            exp_halt   = 1'b0;
            redir_prev = 1'b0;
            prev_pend  = 1'b0;
            prev_addr  = 32'h0;
        end else begin
            if (redir_prev) chk(!valid, "redirect_flush", 32'(valid), 32'h0);
            if (exp_halt) begin
                chk(!valid, "halt_no_valid", 32'(valid), 32'h0);
            end else if (valid) begin
                chk(pc_address == exp_pc, "pc_address", pc_address, exp_pc);
                chk(instruction == instr_of(exp_pc), "instruction", instruction, instr_of(exp_pc));
            end
            if (!valid) chk(instruction == NOP, "nop_when_invalid", instruction, NOP);
            if (prev_pend) chk(imem_req && imem_addr == prev_addr, "req_addr_hold", imem_addr, prev_addr);
            if (imem_req && imem_gnt)
                chk(!m_has || (imem_rvalid && imem_rready), "one_outstanding", 32'(m_has), 32'h0);

            if (redirect) begin
`ifdef FETCH_MISALIGN_EN
                if (redirect_pc[1:0] != 2'b00) exp_halt = 1'b1;
`endif
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (valid && !stall) begin
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            redir_prev = redirect;
            prev_pend  = imem_req && !imem_gnt;
            prev_addr  = imem_addr;
        end
    end

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk(1'b0, name, 32'h0, 32'h1);
    endtask

    initial begin
        logic [31:0] a_hold;
        int          d0;
        int          req_cnt;
        bit          found;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(!imem_req, "reset_req", 32'(imem_req), 32'h0);
        chk(!valid, "reset_valid", 32'(valid), 32'h0);
        chk(instruction == NOP, "reset_instr", instruction, NOP);
        chk(pc_address == 32'h0, "reset_pc_address", pc_address, 32'h0);

        // Zero-wait start-up
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk(imem_req && imem_addr == 32'h0, "first_req", imem_addr, 32'h0);
        tick();
        @(negedge clk);
        chk(imem_addr == 32'h4, "addr_c1", imem_addr, 32'h4);
        chk(!valid, "valid_c1", 32'(valid), 32'h0);
        tick();
        @(negedge clk);
        chk(valid && pc_address == 32'h0, "pc_c2", pc_address, 32'h0);
        chk(instruction == 32'h0050_0093, "instr_c2", instruction, 32'h0050_0093);
        chk(imem_addr == 32'h8, "addr_c2", imem_addr, 32'h8);
        tick();
        @(negedge clk);
        chk(valid && pc_address == 32'h4, "pc_c3", pc_address, 32'h4);
        chk(instruction == 32'h0010_0113, "instr_c3", instruction, 32'h0010_0113);

        // Stall three cycles while 0x8 is presented
        tick();
        stall = 1'b1;
        lat_next = 2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(valid && pc_address == 32'h8, "stall_frozen", pc_address, 32'h8);
            chk(!imem_rready, "stall_rready", 32'(imem_rready), 32'h0);
            chk(!(imem_req && imem_gnt), "stall_no_grant", 32'(imem_gnt), 32'h0);
            tick();
        end
        stall = 1'b0;

        // Redirect to 0x100 while the 0x10 response is outstanding
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && imem_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(found, "grant_0x10_seen", 32'(found), 32'h1);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        stall = 1'b1;
        wait_valid("timeout_0x100");
        chk(pc_address == 32'h100, "redirect_target", pc_address, 32'h100);

        // Redirect while stalled: redirect wins
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        chk(valid && pc_address == 32'h100, "held_before_redirect", pc_address, 32'h100);
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        gnt_ok = 1'b0;
        lat_next = 0;
        @(negedge clk);
        chk(!valid, "redirect_beats_stall", 32'(valid), 32'h0);

        // Grant withheld four cycles, redirect to 0x300 during the wait
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(found, "req_seen_gnt_wait", 32'(found), 32'h1);
        a_hold = imem_addr;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk(imem_req && imem_addr == a_hold, "gnt_wait_hold", imem_addr, a_hold);
            tick();
            redirect = (k == 1);
            redirect_pc = 32'h300;
        end
        redirect = 1'b0;
        gnt_ok = 1'b1;
        wait_valid("timeout_0x300");
        chk(pc_address == 32'h300, "after_gnt_wait", pc_address, 32'h300);

        // Randomized traffic
        d0 = deliveries;
        for (int i = 0; i < 1500; i++) begin
            tick();
            stall = ($urandom_range(0, 3) == 0);
            gnt_ok = ($urandom_range(0, 2) != 0);
            lat_next = $urandom_range(0, 2);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = {24'h0, 6'($urandom), 2'b00};
`ifndef FETCH_MISALIGN_EN
            redirect_pc[1:0] = 2'($urandom);
`endif
        end
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        gnt_ok = 1'b1;
        lat_next = 0;
        chk(deliveries - d0 > 100, "random_progress", 32'(deliveries - d0), 32'd101);

        // Sustained zero-wait throughput
        repeat (10) tick();
        d0 = deliveries;
        repeat (20) tick();
        chk(deliveries - d0 == 20, "throughput", 32'(deliveries - d0), 32'd20);

        // Reset mid-operation
        rst = 1'b0;
        @(negedge clk);
        chk(!imem_req && !valid, "midreset_idle", {imem_req, valid}, 32'h0);
        chk(instruction == NOP && pc_address == 32'h0, "midreset_slot", instruction, NOP);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk(imem_req && imem_addr == 32'h0, "midreset_restart", imem_addr, 32'h0);
        repeat (10) tick();

        // Misaligned redirect target
        redirect = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
        repeat (10) tick();
        @(negedge clk);
        chk(fetch_misaligned, "misaligned_flag", 32'(fetch_misaligned), 32'h1);
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            if (imem_req) req_cnt++;
        end
        chk(req_cnt == 0, "halt_no_req", 32'(req_cnt), 32'h0);
        chk(!valid, "halt_valid", 32'(valid), 32'h0);
`else
        req_cnt = 0;
        wait_valid("timeout_misalign");
        chk(pc_address == 32'h100, "misalign_forced", pc_address, 32'h100);
`endif

        tick();
        rst = 1'b0;
        @(negedge clk);
        chk(!imem_req, "final_reset_req", 32'(imem_req), 32'h0);
`ifdef FETCH_MISALIGN_EN
        chk(!fetch_misaligned, "final_reset_flag", 32'(fetch_misaligned), 32'h0);
`endif
        tick();
        rst = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the in-order RV32I pipeline, directly upstream of decode. It owns the program counter and issues one-outstanding requests to instruction memory over a req/gnt + rvalid/rready handshake. It presents `instruction`, `pc_address` and `valid` to decode, holds them under load-use stall, and flushes on taken branch/jump redirects from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `instruction` when `valid`=0.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `stall` in 1: decode cannot accept this cycle (load-use hazard).
- `redirect` in 1: execute resolved a taken branch, jal or jalr.
- `redirect_pc` in 32: target address, valid with `redirect`.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: request address, word-aligned.
- `imem_gnt` in 1: memory accepted the request this cycle.
- `imem_rvalid` in 1: response data valid; memory holds it until `imem_rready`.
- `imem_rready` out 1: fetch accepts the response.
- `imem_rdata` in 32: fetched instruction.
- `instruction` out 32: to decode.
- `pc_address` out 32: address of `instruction`.
- `valid` out 1: `instruction`/`pc_address` are live.

## Operation
- Registers:
  - `pc`: next request address.
  - `pc_out`: address of the outstanding request.
  - Output slot: `valid`, `instruction`, `pc_address`.
- FSM states:
  - IDLE: nothing outstanding.
  - BUSY: granted, awaiting response.
  - KILL: granted, response will be discarded.
- Request:
  - `imem_req`=1 in IDLE, and in BUSY during the cycle the response is accepted.
  - Once raised, `imem_req` and `imem_addr` stay stable until `imem_gnt`.
- On grant: `pc_out`<=`pc`, `pc`<=`pc`+4 (wraps modulo 2^32), state->BUSY.
- `imem_rready` = (state==KILL) | !`valid` | !`stall`.
- Response accept (`rvalid`&&`rready`) in BUSY: slot <= {1, `imem_rdata`, `pc_out`}. State -> BUSY if granted the same cycle, else IDLE.
- Response accept in KILL: data dropped. State -> IDLE, or BUSY if granted the same cycle.
- Consumption: a slot with `valid`&&!`stall` empties at the edge unless refilled.
- Redirect has priority over stall and response:
  - `valid`<=0 and `instruction`<=`NOP_INSTR` next edge.
  - `pc`<=`redirect_pc` with bits [1:0] forced to 0.
  - A response accepted in that cycle is dropped.
  - BUSY -> KILL.
  - An ungranted pending request completes to KILL on grant; `pc` is not incremented by that grant.
- Simultaneous redirect and response in KILL: response dropped, state -> IDLE.
- `stall` with `valid`=0 has no effect on the slot.

## Timing
- Reset values (asynchronous on `rst` low):
  - `pc`=`RESET_PC`, state=IDLE, `imem_req`=0.
  - `valid`=0, `instruction`=`NOP_INSTR`, `pc_address`=`RESET_PC`.
  - `fetch_misaligned`=0 (when compiled in).
- First cycle after `rst` deasserts: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Zero-wait memory (gnt same cycle, rvalid next cycle):
  - `valid` rises 2 edges after the request cycle.
  - Sustained throughput is 1 instruction/cycle.
- Redirect bubble: redirect cycle N; new request at cycle N+1; first new `valid` at N+3 with zero-wait memory.
- Reset mid-operation: outstanding response forgotten. Memory must also be reset by the same `rst`.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - Adds output `fetch_misaligned` (1 bit, sticky).
  - A redirect with `redirect_pc[1:0]`!=0 sets it, clears `valid` and parks the FSM in a HALT state after any outstanding response drains.
  - No further requests until reset.
- `FETCH_MISALIGN_EN` undefined: port absent, low bits silently forced to 0.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN`=32, `NOP_INSTR`, `RESET_PC` default.
  - FSM state enum `fetch_state_t` (IDLE, BUSY, KILL, HALT).
- One sub-module, `fetch_slot`: output slot register with load/hold/flush controls, reusable for other pipeline registers.
- PC increment and FSM live in `fetch_stage`.

## Test plan
- Reset release, zero-wait memory, rdata 0x00500093, 0x00100113, … → `imem_addr` 0x0, 0x4, 0x8 on consecutive cycles; `valid` continuous from cycle 2; `pc_address` 0x0, 0x4, 0x8.
- `stall` held 3 cycles while `valid`=1 at `pc_address`=0x8 → outputs frozen; `imem_rready`=0; no new grant; fetch resumes at 0xC with no gaps or duplicates.
- Redirect to 0x100 while a response for 0x10 is outstanding → 0x10 never appears on `valid`; next `pc_address` is 0x100.
- Redirect asserted with `stall`=1 → `valid`=0 next edge; redirect wins.
- `imem_gnt` delayed 4 cycles → `imem_addr` stable throughout; redirect during the wait → granted response dropped; then fetch proceeds from the target.
- `FETCH_MISALIGN_EN` defined, `redirect_pc`=0x102 → `fetch_misaligned`=1 and `imem_req` stays 0 until reset. Undefined → fetch proceeds from 0x100.
